// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream loader for the 16x8 SAP program RAM
// Holds the CPU in reset until a whole frame with a good checksum has been written.
module program_loader #(
    parameter int                 ADDR_W    = 4,
    parameter int                 DATA_W    = 8,
    parameter int                 MAX_LEN   = 16,
    parameter logic [DATA_W-1:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q,    state_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic [CNT_W-1:0]  len_q,      len_d;
    logic [DATA_W-1:0] sum_q,      sum_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic              ram_we_q,   ram_we_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              accept;
    logic              is_sync;
    logic [DATA_W-1:0] csum_total;
    logic [CNT_W-1:0]  count_inc;

    // A write cycle blocks the next byte, so at most one data byte lands every two cycles.
    assign in_ready   = ~rst & ~ram_we_q;
    assign accept     = in_valid & in_ready;
    assign is_sync    = (in_data == SYNC_BYTE);
    assign csum_total = sum_q + in_data;
    assign count_inc  = count_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        len_d      = len_q;
        sum_d      = sum_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_we_d   = 1'b0;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
        err_d      = err_q;
        err_code_d = err_code_q;

        if (accept) begin
            case (state_q)
                S_IDLE: begin
                    if (is_sync) state_d = S_LEN;
                end
                S_LEN: begin
                    if (in_data == '0 || in_data > DATA_W'(MAX_LEN)) begin
                        state_d    = S_ERR;
                        err_d      = 1'b1;
                        err_code_d = 2'b01;
                    end else begin
                        state_d = S_DATA;
                        count_d = '0;
                        len_d   = in_data[CNT_W-1:0];
                        sum_d   = in_data;
                    end
                end
                S_DATA: begin
                    sum_d      = csum_total;
                    ram_addr_d = count_q[ADDR_W-1:0];
                    ram_data_d = in_data;
                    ram_we_d   = 1'b1;
                    count_d    = count_inc;
                    if (count_inc == len_q) state_d = S_CSUM;
                end
                S_CSUM: begin
                    if (csum_total == '0) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d    = S_ERR;
                        err_d      = 1'b1;
                        err_code_d = 2'b10;
                    end
                end
                S_DONE, S_ERR: begin
                    // Re-arming holds the CPU on the same edge the new frame starts.
                    if (is_sync) begin
                        state_d    = S_LEN;
                        done_d     = 1'b0;
                        err_d      = 1'b0;
                        err_code_d = 2'b00;
                        cpu_hold_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            len_q      <= '0;
            sum_q      <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_we_q   <= 1'b0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_we_q   <= ram_we_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;
    assign ram_we   = ram_we_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule
